// File: rtl/phase_tdc.sv
// Signed phase-error TDC: synchronises ref/fb edges, counts the gap between them in clk cycles
// and hands each result over valid/ready. Define PHASE_TDC_AVG_EN to average 2^AVG_LOG2 samples.
module phase_tdc #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             fb_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W:0]   phase_err,
  output logic             fb_lead,
  output logic             overflow,
  output logic [1:0]       fsm_state
);

  // Handshake: a result transfers on a cycle where meas_valid && meas_ready; while valid and
  // not ready the outputs hold; after transfer the data outputs keep their value.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REF_FIRST = 2'd1,
    FB_FIRST  = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Out-of-range parameters leave this visibly named block in the elaborated hierarchy.
  if (SYNC_STAGES < 2 || AVG_LOG2 < 1) begin : g_param_out_of_range
  end

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
  logic                   ref_last, fb_last;
  logic                   ref_p, fb_p;
  logic [CNT_W-1:0]       count_q, count_d, count_inc;
  logic                   sample_done, sample_neg, sample_ovf;
  logic [CNT_W-1:0]       sample_mag;
  logic [CNT_W:0]         sample_pos, sample_val;
  logic                   group_last, result_load;
  logic [CNT_W:0]         result_err;
  logic                   result_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_last <= 1'b0;
      fb_last  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
      ref_last <= ref_sync[SYNC_STAGES-1];
      fb_last  <= fb_sync[SYNC_STAGES-1];
    end
  end

  assign ref_p = ref_sync[SYNC_STAGES-1] & ~ref_last;
  assign fb_p  = fb_sync[SYNC_STAGES-1] & ~fb_last;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (sample_done) state_d = group_last ? HOLD : IDLE;
          else if (ref_p)  state_d = REF_FIRST;
          else if (fb_p)   state_d = FB_FIRST;
        end
      end
      REF_FIRST, FB_FIRST: begin
        if (!enable)          state_d = IDLE;
        else if (sample_done) state_d = group_last ? HOLD : IDLE;
      end
      HOLD: begin
        if (meas_valid && meas_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic: the count includes the closing cycle, so a sample is count+1.
  assign count_inc = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;

  always_comb begin
    sample_done = 1'b0;
    sample_neg  = 1'b0;
    sample_ovf  = 1'b0;
    sample_mag  = '0;
    count_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && ref_p && fb_p) sample_done = 1'b1;
      end
      REF_FIRST: begin
        if (enable) begin
          if (fb_p) begin
            sample_done = 1'b1;
            sample_mag  = count_inc;
            sample_ovf  = (count_q == CNT_MAX);
          end else if (!ref_p) begin
            count_d = count_inc;
          end
        end
      end
      FB_FIRST: begin
        if (enable) begin
          if (ref_p) begin
            sample_done = 1'b1;
            sample_neg  = 1'b1;
            sample_mag  = count_inc;
            sample_ovf  = (count_q == CNT_MAX);
          end else if (!fb_p) begin
            count_d = count_inc;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign sample_pos = {1'b0, sample_mag};
  assign sample_val = sample_neg ? -sample_pos : sample_pos;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

`ifdef PHASE_TDC_AVG_EN
  localparam int ACC_W = CNT_W + 1 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] IDX_LAST = (AVG_LOG2 + 1)'((2 ** AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc_q, acc_sum, acc_shift, sample_ext;
  logic [AVG_LOG2:0]       idx_q;
  logic                    acc_ovf_q;

  assign sample_ext = ACC_W'($signed(sample_val));
  assign acc_sum    = acc_q + sample_ext;
  assign acc_shift  = acc_sum >>> AVG_LOG2;
  assign group_last = (idx_q == IDX_LAST);
  assign result_err = acc_shift[CNT_W:0];
  assign result_ovf = acc_ovf_q | sample_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      idx_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else if (!enable || (sample_done && group_last)) begin
      acc_q     <= '0;
      idx_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else if (sample_done) begin
      acc_q     <= acc_sum;
      idx_q     <= idx_q + 1'b1;
      acc_ovf_q <= acc_ovf_q | sample_ovf;
    end
  end
`else
  assign group_last = 1'b1;
  assign result_err = sample_val;
  assign result_ovf = sample_ovf;
`endif

  assign result_load = sample_done && group_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meas_valid <= 1'b0;
      phase_err  <= '0;
      fb_lead    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (meas_valid && meas_ready) meas_valid <= 1'b0;
      if (result_load) begin
        meas_valid <= 1'b1;
        phase_err  <= result_err;
        fb_lead    <= result_err[CNT_W];
        overflow   <= result_ovf;
      end
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_phase_tdc.sv
// Directed bench for phase_tdc: a 12-bit and a 4-bit instance share all stimulus.
module tb_phase_tdc;

  localparam int CNT_W   = 12;
  localparam int CNT_W_S = 4;
  localparam int SYNC    = 2;

  logic               clk = 1'b0;
  logic               reset_n, enable, ref_in, fb_in, meas_ready;
  logic               meas_valid, fb_lead, overflow;
  logic [CNT_W:0]     phase_err;
  logic [1:0]         fsm_state;
  logic               meas_valid_s, fb_lead_s, overflow_s;
  logic [CNT_W_S:0]   phase_err_s;
  logic [1:0]         fsm_state_s;

  int checks = 0;
  int errors = 0;

  phase_tdc #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .AVG_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .meas_ready(meas_ready), .meas_valid(meas_valid), .phase_err(phase_err),
    .fb_lead(fb_lead), .overflow(overflow), .fsm_state(fsm_state)
  );

  phase_tdc #(.CNT_W(CNT_W_S), .SYNC_STAGES(SYNC), .AVG_LOG2(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .meas_ready(meas_ready), .meas_valid(meas_valid_s), .phase_err(phase_err_s),
    .fb_lead(fb_lead_s), .overflow(overflow_s), .fsm_state(fsm_state_s)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    reset_n = 1'b0;
    ref_in  = 1'b0;
    fb_in   = 1'b0;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Raises ref at cycle rd and fb at cycle fd; returns on the cycle of the later rise.
  task automatic drive_pair(input int rd, input int fd);
    int last;
    last = (rd > fd) ? rd : fd;
    for (int c = 0; c <= last; c++) begin
      if (c == rd) ref_in = 1'b1;
      if (c == fd) fb_in  = 1'b1;
      if (c < last) @(negedge clk);
    end
  endtask

  task automatic release_inputs();
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!meas_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    string name;
    int    rd;
    int    fd;
    int    err;
    int    ovf;
    int    err_s;
    int    ovf_s;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int saw;
    meas_ready = 1'b1;
    do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_valid", meas_valid, 0);
    check("reset_err", $signed(phase_err), 0);
    check("reset_lead", fb_lead, 0);
    check("reset_ovf", overflow, 0);
    check("reset_state", fsm_state, 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifndef PHASE_TDC_AVG_EN
    vecs[0] = '{"fb_lags5",    2,  7,   5, 0,   5, 0};
    vecs[1] = '{"fb_leads7",   9,  2,  -7, 0,  -7, 0};
    vecs[2] = '{"coincident",  3,  3,   0, 0,   0, 0};
    vecs[3] = '{"sat_pos20",   2, 22,  20, 0,  15, 1};
    vecs[4] = '{"exact_max15", 4, 19,  15, 0,  15, 0};
    vecs[5] = '{"sat_neg16",  30, 14, -16, 0, -15, 1};
    vecs[6] = '{"fb_lags1",    1,  2,   1, 0,   1, 0};

    foreach (vecs[i]) begin
      do_reset();
      meas_ready = 1'b1;
      drive_pair(vecs[i].rd, vecs[i].fd);
      wait_valid(lat);
      check({vecs[i].name, "_latency"}, lat, SYNC + 1);
      check({vecs[i].name, "_err"}, $signed(phase_err), vecs[i].err);
      check({vecs[i].name, "_lead"}, fb_lead, (vecs[i].err < 0) ? 1 : 0);
      check({vecs[i].name, "_ovf"}, overflow, vecs[i].ovf);
      check({vecs[i].name, "_valid_s"}, meas_valid_s, 1);
      check({vecs[i].name, "_err_s"}, $signed(phase_err_s), vecs[i].err_s);
      check({vecs[i].name, "_ovf_s"}, overflow_s, vecs[i].ovf_s);
      @(negedge clk);
      check({vecs[i].name, "_valid_pulse"}, meas_valid, 0);
      check({vecs[i].name, "_err_kept"}, $signed(phase_err), vecs[i].err);
    end

    // Back-pressure: result frozen while edges keep arriving, fresh edges measured afterwards.
    do_reset();
    meas_ready = 1'b0;
    drive_pair(1, 5);
    wait_valid(lat);
    check("bp_first_valid", meas_valid, 1);
    check("bp_first_err", $signed(phase_err), 4);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) ref_in = 1'b1;
      if (c == 5) fb_in  = 1'b1;
      if (c == 8) begin
        ref_in = 1'b0;
        fb_in  = 1'b0;
      end
      @(negedge clk);
      check("bp_hold_valid", meas_valid, 1);
      check("bp_hold_err", $signed(phase_err), 4);
    end
    meas_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_valid", meas_valid, 0);
    check("bp_accept_err_kept", $signed(phase_err), 4);
    check("bp_accept_state", fsm_state, 0);
    drive_pair(6, 3);
    wait_valid(lat);
    check("bp_fresh_latency", lat, SYNC + 1);
    check("bp_fresh_err", $signed(phase_err), -3);
    check("bp_fresh_lead", fb_lead, 1);
    release_inputs();

    // Asynchronous reset in the middle of a measurement.
    ref_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_state_before", fsm_state, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_state", fsm_state, 0);
    check("rst_mid_err", $signed(phase_err), 0);
    check("rst_mid_lead", fb_lead, 0);
    @(negedge clk);
    ref_in  = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    drive_pair(1, 4);
    wait_valid(lat);
    check("rst_mid_fresh_err", $signed(phase_err), 3);

    // Enable low aborts an open measurement; the later fb edge starts a new one.
    do_reset();
    ref_in = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_open_state", fsm_state, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idle_state", fsm_state, 0);
    enable = 1'b1;
    fb_in  = 1'b1;
    saw    = 0;
    repeat (8) begin
      @(negedge clk);
      if (meas_valid) saw = 1;
    end
    check("abort_no_result", saw, 0);
    check("abort_fb_first_state", fsm_state, 2);
`else
    begin
      int grp_a[4];
      int grp_b[4];
      grp_a = '{3, 4, -2, 6};
      grp_b = '{-1, -1, -1, -2};

      do_reset();
      meas_ready = 1'b1;
      foreach (grp_a[i]) begin
        if (grp_a[i] >= 0) drive_pair(1, 1 + grp_a[i]);
        else               drive_pair(1 - grp_a[i], 1);
        if (i < 3) begin
          saw = 0;
          repeat (6) begin
            @(negedge clk);
            if (meas_valid) saw = 1;
          end
          check("avg_partial_no_valid", saw, 0);
        end else begin
          wait_valid(lat);
          check("avg_latency", lat, SYNC + 1);
          check("avg_err", $signed(phase_err), 2);
          check("avg_lead", fb_lead, 0);
          check("avg_ovf", overflow, 0);
          @(negedge clk);
          check("avg_valid_pulse", meas_valid, 0);
        end
        release_inputs();
      end

      // Two samples into a group, then reset: the next group must start from zero.
      drive_pair(1, 6);
      repeat (5) @(negedge clk);
      release_inputs();
      drive_pair(1, 6);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("avg_rst_valid", meas_valid, 0);
      check("avg_rst_err", $signed(phase_err), 0);
      @(negedge clk);
      ref_in  = 1'b0;
      fb_in   = 1'b0;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      foreach (grp_b[i]) begin
        drive_pair(1 - grp_b[i], 1);
        if (i < 3) begin
          saw = 0;
          repeat (6) begin
            @(negedge clk);
            if (meas_valid) saw = 1;
          end
          check("avg_b_partial_no_valid", saw, 0);
        end else begin
          wait_valid(lat);
          check("avg_b_latency", lat, SYNC + 1);
          check("avg_b_err_floor", $signed(phase_err), -2);
          check("avg_b_lead", fb_lead, 1);
        end
        release_inputs();
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
